// File: rtl/key_pkg.sv
// Shared types and 100 kHz timing defaults for the panel key conditioning stage.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int DEB_20MS        = 2000;
  localparam int REP_DELAY_500MS = 50000;
  localparam int REP_RATE_100MS  = 10000;

  // Bits needed for a counter that runs 0 .. max_val-1 (never narrower than 1).
  function automatic int cnt_width(input int max_val);
    if (max_val <= 2) begin
      return 1;
    end else begin
      return $clog2(max_val);
    end
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM and long-press auto-repeat.
module key_debounce_ch import key_pkg::*; #(
  parameter int DEB_CYCLES   = DEB_20MS,
  parameter int REPEAT_DELAY = REP_DELAY_500MS,
  parameter int REPEAT_RATE  = REP_RATE_100MS
) (
  input  logic clk100khz,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int                DEB_W      = cnt_width(DEB_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam bit                REP_EN     = (REPEAT_DELAY > 0);
  localparam int                REP_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int                REP_W      = cnt_width(REP_MAX);
  localparam logic [REP_W-1:0]  DELAY_LAST = REP_W'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0]  RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic             sync1_r;
  logic             sync_n_r;
  key_state_e       state_r, state_s;
  logic [DEB_W-1:0] deb_cnt_r, deb_cnt_s;
  logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
  logic             rep_phase_r, rep_phase_s;
  logic             level_r, level_s;
  logic             press_r, press_s;
  logic             release_r, release_s;
  logic [REP_W-1:0] rep_target_s;
  logic             rep_hit_s;
  logic [REP_W-1:0] rep_adv_cnt_s;
  logic             rep_adv_phase_s;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk100khz or negedge rst) begin
    if (!rst) begin
      sync1_r  <= 1'b1;
      sync_n_r <= 1'b1;
    end else begin
      sync1_r  <= key_n;
      sync_n_r <= sync1_r;
    end
  end

  // Auto-repeat step: phase 0 waits for the initial delay, phase 1 for the rate.
  always_comb begin
    rep_target_s    = rep_phase_r ? RATE_LAST : DELAY_LAST;
    rep_hit_s       = 1'b0;
    rep_adv_cnt_s   = rep_cnt_r;
    rep_adv_phase_s = rep_phase_r;
    if (REP_EN) begin
      if (rep_cnt_r == rep_target_s) begin
        rep_hit_s       = 1'b1;
        rep_adv_cnt_s   = '0;
        rep_adv_phase_s = 1'b1;
      end else begin
        rep_adv_cnt_s   = rep_cnt_r + 1'b1;
      end
    end else begin
      rep_adv_cnt_s = rep_cnt_r;
    end
  end

  // Next-state and next-output logic for the debounce FSM.
  always_comb begin
    state_s     = state_r;
    deb_cnt_s   = deb_cnt_r;
    rep_cnt_s   = rep_cnt_r;
    rep_phase_s = rep_phase_r;
    level_s     = level_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        level_s = 1'b0;
        if (!sync_n_r) begin
          state_s   = PRESS_WAIT;
          deb_cnt_s = '0;
        end else begin
          state_s   = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (sync_n_r) begin
          state_s = IDLE;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_s     = HELD;
          level_s     = 1'b1;
          press_s     = 1'b1;
          rep_cnt_s   = '0;
          rep_phase_s = 1'b0;
        end else begin
          deb_cnt_s = deb_cnt_r + 1'b1;
        end
      end
      HELD: begin
        if (sync_n_r) begin
          state_s   = RELEASE_WAIT;
          deb_cnt_s = '0;
        end else begin
          rep_cnt_s   = rep_adv_cnt_s;
          rep_phase_s = rep_adv_phase_s;
          press_s     = rep_hit_s;
        end
      end
      RELEASE_WAIT: begin
        // A low sample here ends the release bounce and counts as a held cycle.
        if (!sync_n_r) begin
          state_s     = HELD;
          rep_cnt_s   = rep_adv_cnt_s;
          rep_phase_s = rep_adv_phase_s;
          press_s     = rep_hit_s;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_s   = IDLE;
          level_s   = 1'b0;
          release_s = 1'b1;
        end else begin
          deb_cnt_s = deb_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        level_s = 1'b0;
      end
    endcase
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk100khz or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      deb_cnt_r   <= '0;
      rep_cnt_r   <= '0;
      rep_phase_r <= 1'b0;
      level_r     <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      deb_cnt_r   <= deb_cnt_s;
      rep_cnt_r   <= rep_cnt_s;
      rep_phase_r <= rep_phase_s;
      level_r     <= level_s;
      press_r     <= press_s;
      release_r   <= release_s;
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/key_debounce_chk.sv
// Protocol checker for the key outputs: pulses are exclusive and agree with the level.
module key_debounce_chk #(
  parameter int N_KEYS = 3
) (
  input logic              clk100khz,
  input logic              rst,
  input logic [N_KEYS-1:0] key_level,
  input logic [N_KEYS-1:0] key_press,
  input logic [N_KEYS-1:0] key_release
);

  a_pulse_excl: assert property (@(posedge clk100khz) disable iff (!rst)
    (key_press & key_release) == '0);

  a_press_level: assert property (@(posedge clk100khz) disable iff (!rst)
    (key_press & ~key_level) == '0);

  a_release_level: assert property (@(posedge clk100khz) disable iff (!rst)
    (key_release & key_level) == '0);

endmodule

// File: rtl/key_debounce.sv
// Panel key front end: N_KEYS independent synchronise/debounce/auto-repeat channels.
module key_debounce import key_pkg::*; #(
  parameter int N_KEYS       = 3,
  parameter int DEB_CYCLES   = DEB_20MS,
  parameter int REPEAT_DELAY = REP_DELAY_500MS,
  parameter int REPEAT_RATE  = REP_RATE_100MS
) (
  input  logic              clk100khz,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk100khz   (clk100khz),
      .rst         (rst),
      .key_n       (key_n[gi]),
      .key_level   (key_level[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi])
    );
  end

  key_debounce_chk #(
    .N_KEYS (N_KEYS)
  ) u_chk (
    .clk100khz   (clk100khz),
    .rst         (rst),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce with a run-length reference model and pulse scoreboard.
module tb_key_debounce;

  localparam int NK    = 3;
  localparam int DEB   = 4;
  localparam int RDLY  = 20;
  localparam int RRATE = 8;

  logic          clk100khz = 1'b0;
  logic          rst       = 1'b0;
  logic [NK-1:0] key_n     = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  key_debounce #(
    .N_KEYS       (NK),
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RDLY),
    .REPEAT_RATE  (RRATE)
  ) dut (
    .clk100khz   (clk100khz),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk100khz = ~clk100khz;

  typedef struct {
    int cyc;
    int ch;
    bit press;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  cyc    = 0;

  // Reference model state: synchroniser copy, accepted level, mismatch run, held-cycle count.
  bit [NK-1:0] m_s1, m_s2, m_lvl;
  int          m_run[NK];
  int          m_h[NK];
  bit          m_p;

  // Monitor-side observations used by directed checks.
  int npress[NK];
  int nrel[NK];
  int fp[NK];
  int fr[NK];
  bit [NK-1:0] ep, er;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: dut=%0d expected=%0d", name, act, req);
  endtask

  task automatic push(input int ch, input bit press);
    ev_t e;
    e.cyc   = cyc;
    e.ch    = ch;
    e.press = press;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk100khz);
  endtask

  // A change is accepted after DEB+1 consecutive synchronised samples that disagree with the level;
  // repeats fire on the RDLY-th held sample after acceptance and every RRATE held samples after.
  initial begin
    forever begin
      @(posedge clk100khz or negedge rst);
      if (!rst) begin
        m_s1  = '1;
        m_s2  = '1;
        m_lvl = '0;
        for (int i = 0; i < NK; i++) begin
          m_run[i] = 0;
          m_h[i]   = 0;
        end
      end else begin
        cyc++;
        for (int i = 0; i < NK; i++) begin
          m_p = ~m_s2[i];
          if (m_p != m_lvl[i]) m_run[i]++;
          else m_run[i] = 0;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i] = m_p;
            m_run[i] = 0;
            m_h[i]   = 0;
            push(i, m_p);
          end else if (m_lvl[i] && m_p && RDLY != 0) begin
            m_h[i]++;
            if (m_h[i] == RDLY || (m_h[i] > RDLY && (m_h[i] - RDLY) % RRATE == 0))
              push(i, 1'b1);
          end
        end
        m_s2 = m_s1;
        m_s1 = key_n;
      end
    end
  end

  // Scoreboard monitor: every cycle, pop the events due now and compare pulses and levels.
  initial begin
    for (int i = 0; i < NK; i++) begin
      npress[i] = 0;
      nrel[i]   = 0;
      fp[i]     = -1;
      fr[i]     = -1;
    end
    forever begin
      @(negedge clk100khz);
      if (rst) begin
        ep = '0;
        er = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].cyc <= cyc) begin
            if (exp_q[i].press) ep[exp_q[i].ch] = 1'b1;
            else er[exp_q[i].ch] = 1'b1;
            exp_q.delete(i);
          end
        end
        for (int i = 0; i < NK; i++) begin
          check($sformatf("key_press[%0d] cyc %0d", i, cyc), int'(key_press[i]), int'(ep[i]));
          check($sformatf("key_release[%0d] cyc %0d", i, cyc), int'(key_release[i]), int'(er[i]));
          check($sformatf("key_level[%0d] cyc %0d", i, cyc), int'(key_level[i]), int'(m_lvl[i]));
          if (key_press[i]) begin
            npress[i]++;
            if (fp[i] < 0) fp[i] = cyc;
          end
          if (key_release[i]) begin
            nrel[i]++;
            if (fr[i] < 0) fr[i] = cyc;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int start;
  int n0, r0;
  int rem[NK];

  initial begin
    rst   = 1'b0;
    key_n = '1;
    step(2);
    check("reset key_level", int'(key_level), 0);
    check("reset key_press", int'(key_press), 0);
    check("reset key_release", int'(key_release), 0);
    rst = 1'b1;
    step(3);

    // Clean press on channel 0.
    fp[0] = -1;
    start = cyc;
    key_n[0] = 1'b0;
    step(12);
    check("press latency ch0", fp[0] - start, 7);
    check("level after press ch0", int'(key_level), 1);

    // Clean release on channel 0.
    fr[0] = -1;
    n0 = npress[0];
    start = cyc;
    key_n[0] = 1'b1;
    step(12);
    check("release latency ch0", fr[0] - start, 7);
    check("no press during release ch0", npress[0] - n0, 0);

    // Bounce shorter than the debounce window.
    n0 = npress[0];
    r0 = nrel[0];
    key_n[0] = 1'b0; step(3);
    key_n[0] = 1'b1; step(1);
    key_n[0] = 1'b0; step(2);
    key_n[0] = 1'b1; step(12);
    check("bounce press count ch0", npress[0] - n0, 0);
    check("bounce release count ch0", nrel[0] - r0, 0);

    // Long hold on channel 1: acceptance plus repeats at +20,+28,+36,+44,+52.
    n0 = npress[1];
    r0 = nrel[1];
    key_n[1] = 1'b0;
    step(7 + 58);
    check("auto-repeat press count ch1", npress[1] - n0, 6);

    // Short release bounce while held shifts the repeat schedule by its length.
    key_n[1] = 1'b1; step(2);
    key_n[1] = 1'b0; step(40);
    check("level held through bounce ch1", int'(key_level[1]), 1);
    check("no release during bounce ch1", nrel[1] - r0, 0);
    key_n[1] = 1'b1; step(12);
    check("single release ch1", nrel[1] - r0, 1);

    // Reset while channel 0 is held and channel 2 is mid-debounce.
    key_n[0] = 1'b0; step(10);
    key_n[2] = 1'b0; step(4);
    check("level before reset", int'(key_level), 1);
    #2 rst = 1'b0;
    #1;
    check("async reset key_level", int'(key_level), 0);
    check("async reset key_press", int'(key_press), 0);
    check("async reset key_release", int'(key_release), 0);
    @(negedge clk100khz);
    #2;
    fp[0] = -1;
    fp[2] = -1;
    start = cyc;
    rst = 1'b1;
    step(12);
    check("press latency after reset ch0", fp[0] - start, 7);
    check("press latency after reset ch2", fp[2] - start, 7);
    key_n = '1;
    step(12);

    // Randomised run lengths, mixing glitches and long holds.
    for (int i = 0; i < NK; i++) rem[i] = 0;
    repeat (1500) begin
      for (int i = 0; i < NK; i++) begin
        if (rem[i] == 0) begin
          key_n[i] = ~key_n[i];
          if ($urandom_range(3, 0) == 0) rem[i] = int'($urandom_range(60, DEB + 1));
          else rem[i] = int'($urandom_range(DEB + 2, 1));
        end else begin
          rem[i]--;
        end
      end
      step(1);
    end

    key_n = '1;
    step(20);
    check("scoreboard drained", exp_q.size(), 0);
    check("final key_level", int'(key_level), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
